// File: rtl/avfs_dfs_ctrl.sv
// ---------------------------------------------------------------------------
// avfs_dfs_ctrl: activity-driven dynamic frequency scaling controller.
//
// Each channel counts the busy cycles in a shared observation window. At the
// end of a window the count is compared against two thresholds to request a
// faster (UP) or slower (DOWN) clock. A per-channel hysteresis counter makes
// sure a request repeats for HYST windows before the divider select moves by
// one step. A boost bit drops a busy channel straight to full speed, and a
// software override can pin any channel to a fixed divider.
//
// Ports
//   clk_i, rst_i         single clock, synchronous active-high reset
//   activity_i[N_CH]     per-channel busy indication
//   cfg_req_i/we_i/addr_i/wdata_i  register access request
//   cfg_rvalid_o/rdata_o           read response
//   div_sel_o            channel n divider select in [n*DIV_W +: DIV_W]
//   clk_en_o[N_CH]       per-channel enable pulse, one every div_sel+1 cycles
//
// Register port: there is no back-pressure. A request with cfg_req_i=1 is
// accepted in the same cycle; a write lands at the next edge, a read answers
// with cfg_rvalid_o=1 and cfg_rdata_o exactly one cycle later.
// ---------------------------------------------------------------------------
module avfs_dfs_ctrl #(
    parameter int N_CH  = 2,
    parameter int WIN_W = 8,
    parameter int DIV_W = 4,
    parameter int HYST  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_CH-1:0]        activity_i,
    input  logic                   cfg_req_i,
    input  logic                   cfg_we_i,
    input  logic [7:0]             cfg_addr_i,
    input  logic [31:0]            cfg_wdata_i,
    output logic                   cfg_rvalid_o,
    output logic [31:0]            cfg_rdata_o,
    output logic [N_CH*DIV_W-1:0]  div_sel_o,
    output logic [N_CH-1:0]        clk_en_o
);

    localparam logic [7:0] ADDR_CTRL = 8'h00;
    localparam logic [7:0] ADDR_WIN  = 8'h04;
    localparam logic [7:0] ADDR_THH  = 8'h08;
    localparam logic [7:0] ADDR_THL  = 8'h0C;
    localparam logic [7:0] ADDR_DMAX = 8'h10;
    localparam logic [7:0] ADDR_OVR  = 8'h14;

    localparam int HC_W = (HYST < 2) ? 1 : $clog2(HYST + 1);

    localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [HC_W-1:0]  HC_ONE     = HC_W'(1);
    localparam logic [HC_W-1:0]  HC_HYST    = HC_W'(HYST);
    localparam logic [WIN_W-1:0] THR_HI_RST = WIN_W'(3 << (WIN_W - 2));
    localparam logic [WIN_W-1:0] THR_LO_RST = WIN_W'(1 << (WIN_W - 3));

    logic [1:0]       ctrl_q, ctrl_d;
    logic [WIN_W-1:0] win_len_q, win_len_d;
    logic [WIN_W-1:0] thr_hi_q, thr_hi_d;
    logic [WIN_W-1:0] thr_lo_q, thr_lo_d;
    logic [DIV_W-1:0] div_max_q, div_max_d;
    logic [N_CH-1:0]  ovr_en_q, ovr_en_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             rvalid_q;
    logic [31:0]      rdata_q, rdata_d;

    logic             wr_en, win_len_wr, en, boost, win_end;
    logic [WIN_W-1:0] win_last;

    assign wr_en      = cfg_req_i & cfg_we_i;
    assign win_len_wr = wr_en && (cfg_addr_i == ADDR_WIN);
    assign en         = ctrl_q[0];
    assign boost      = ctrl_q[1];
    // A window length of 0 is treated as 1 so the window always ends.
    assign win_last   = (win_len_q == '0) ? '0 : win_len_q - WIN_ONE;
    assign win_end    = en && (win_cnt_q >= win_last);

    always_comb begin
        ctrl_d    = ctrl_q;
        win_len_d = win_len_q;
        thr_hi_d  = thr_hi_q;
        thr_lo_d  = thr_lo_q;
        div_max_d = div_max_q;
        ovr_en_d  = ovr_en_q;
        if (wr_en) begin
            case (cfg_addr_i)
                ADDR_CTRL: ctrl_d    = cfg_wdata_i[1:0];
                ADDR_WIN:  win_len_d = cfg_wdata_i[WIN_W-1:0];
                ADDR_THH:  thr_hi_d  = cfg_wdata_i[WIN_W-1:0];
                ADDR_THL:  thr_lo_d  = cfg_wdata_i[WIN_W-1:0];
                ADDR_DMAX: div_max_d = cfg_wdata_i[DIV_W-1:0];
                ADDR_OVR:  ovr_en_d  = cfg_wdata_i[N_CH-1:0];
                default:   ;
            endcase
        end
        win_cnt_d = (!en || win_len_wr || win_end) ? '0 : win_cnt_q + WIN_ONE;
    end

    always_comb begin
        rdata_d = '0;
        case (cfg_addr_i)
            ADDR_CTRL: rdata_d = {30'd0, ctrl_q};
            ADDR_WIN:  rdata_d = 32'(win_len_q);
            ADDR_THH:  rdata_d = 32'(thr_hi_q);
            ADDR_THL:  rdata_d = 32'(thr_lo_q);
            ADDR_DMAX: rdata_d = 32'(div_max_q);
            ADDR_OVR:  rdata_d = 32'(ovr_en_q);
            default: begin
                for (int n = 0; n < N_CH; n++) begin
                    if (cfg_addr_i == 8'(32'h20 + 4 * n))
                        rdata_d = 32'(div_sel_o[n*DIV_W +: DIV_W]);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q    <= 2'b01;
            win_len_q <= '1;
            thr_hi_q  <= THR_HI_RST;
            thr_lo_q  <= THR_LO_RST;
            div_max_q <= '1;
            ovr_en_q  <= '0;
            win_cnt_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            win_len_q <= win_len_d;
            thr_hi_q  <= thr_hi_d;
            thr_lo_q  <= thr_lo_d;
            div_max_q <= div_max_d;
            ovr_en_q  <= ovr_en_d;
            win_cnt_q <= win_cnt_d;
            rvalid_q  <= cfg_req_i & ~cfg_we_i;
            rdata_q   <= (cfg_req_i & ~cfg_we_i) ? rdata_d : '0;
        end
    end

    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        localparam logic [7:0] CH_ADDR = 8'(32'h20 + 4 * n);

        logic [DIV_W-1:0] div_sel_q, div_sel_d;
        logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
        logic [WIN_W-1:0] act_q, act_d, act_tot;
        logic [HC_W-1:0]  hyst_q, hyst_d, hyst_win;
        logic             dir_up_q, dir_up_d;
        logic [31:0]      ovr_val_q, ovr_val_d;
        logic [DIV_W-1:0] ovr_clip;
        logic             ch_wr, up_req, dn_req, step_now;

        assign ch_wr = wr_en && (cfg_addr_i == CH_ADDR);

        always_comb begin
            ovr_val_d = ch_wr ? cfg_wdata_i : ovr_val_q;
            // Full-width compare so an override larger than DIV_W bits clips.
            ovr_clip  = (ovr_val_q > 32'(div_max_d)) ? div_max_d : ovr_val_q[DIV_W-1:0];

            // Busy count including this cycle; this is what the window-end
            // decision sees, so the last cycle of a window counts.
            act_tot = (act_q == '1) ? act_q
                                    : act_q + {{(WIN_W-1){1'b0}}, activity_i[n]};
            act_d   = (!en || win_len_wr || win_end) ? '0 : act_tot;

            up_req = (act_tot >= thr_hi_q);
            dn_req = !up_req && (act_tot <= thr_lo_q);
            if (up_req)      hyst_win = dir_up_q  ? hyst_q + HC_ONE : HC_ONE;
            else if (dn_req) hyst_win = !dir_up_q ? hyst_q + HC_ONE : HC_ONE;
            else             hyst_win = '0;
            step_now = (hyst_win >= HC_HYST);

            div_sel_d = div_sel_q;
            hyst_d    = hyst_q;
            dir_up_d  = dir_up_q;
            if (ovr_en_q[n]) begin
                div_sel_d = ovr_clip;
                hyst_d    = '0;
            end else if (!en) begin
                hyst_d = '0;
            end else if (boost && activity_i[n] && (div_sel_q != '0)) begin
                div_sel_d = '0;
                hyst_d    = '0;
            end else if (win_end) begin
                if (up_req || dn_req) dir_up_d = up_req;
                if (step_now) begin
                    hyst_d = '0;
                    if (up_req)
                        div_sel_d = (div_sel_q == '0) ? '0 : div_sel_q - DIV_ONE;
                    else
                        div_sel_d = (div_sel_q >= div_max_q) ? div_max_q
                                                             : div_sel_q + DIV_ONE;
                end else begin
                    hyst_d = hyst_win;
                end
            end
            // Uses the incoming DIV_MAX so a lowering write clamps at once.
            if (div_sel_d > div_max_d) div_sel_d = div_max_d;

            // Restart the divider on any select change so the new period
            // opens with an enable pulse.
            if (div_sel_d != div_sel_q)     div_cnt_d = '0;
            else if (div_cnt_q >= div_sel_q) div_cnt_d = '0;
            else                             div_cnt_d = div_cnt_q + DIV_ONE;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                div_sel_q <= '0;
                div_cnt_q <= '0;
                act_q     <= '0;
                hyst_q    <= '0;
                dir_up_q  <= 1'b0;
                ovr_val_q <= '0;
            end else begin
                div_sel_q <= div_sel_d;
                div_cnt_q <= div_cnt_d;
                act_q     <= act_d;
                hyst_q    <= hyst_d;
                dir_up_q  <= dir_up_d;
                ovr_val_q <= ovr_val_d;
            end
        end

        assign div_sel_o[n*DIV_W +: DIV_W] = div_sel_q;
        assign clk_en_o[n]                 = (div_cnt_q == '0);
    end

endmodule

// File: tb/tb_avfs_dfs_ctrl.sv
// ---------------------------------------------------------------------------
// tb_avfs_dfs_ctrl: directed self-checking bench for avfs_dfs_ctrl
// (N_CH=2, WIN_W=8, DIV_W=4, HYST=2). Register access is table driven; the
// window, hysteresis, boost, override and reset scenarios are hand sequences
// with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_avfs_dfs_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  activity;
    logic        cfg_req;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;
    logic [7:0]  div_sel;
    logic [1:0]  clk_en;

    int n_checks = 0;
    int n_pass   = 0;

    avfs_dfs_ctrl #(
        .N_CH  (2),
        .WIN_W (8),
        .DIV_W (4),
        .HYST  (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .activity_i   (activity),
        .cfg_req_i    (cfg_req),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rvalid_o (cfg_rvalid),
        .cfg_rdata_o  (cfg_rdata),
        .div_sel_o    (div_sel),
        .clk_en_o     (clk_en)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [20];
    int   n_vecs = 0;

    task automatic add_vec(input string nm, input logic w, input logic [7:0] a,
                           input logic [31:0] d);
        vecs[n_vecs].name = nm;
        vecs[n_vecs].we   = w;
        vecs[n_vecs].addr = a;
        vecs[n_vecs].data = d;
        n_vecs++;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled at the same point (state after the edge).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_req   = 1'b0;
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d,
                            output logic v);
        cfg_req  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = a;
        step();
        cfg_req  = 1'b0;
        d = cfg_rdata;
        v = cfg_rvalid;
    endtask

    // one 8-cycle window on ch0 with n_act busy cycles, either leading or
    // trailing (trailing puts a busy cycle on the window-end cycle)
    task automatic run_window(input int n_act, input bit trailing);
        for (int i = 0; i < 8; i++) begin
            activity[0] = trailing ? (i >= 8 - n_act) : (i < n_act);
            step();
        end
        activity = 2'b00;
    endtask

    logic [31:0] rd;
    logic        rv;
    logic [5:0]  en_a, en_b, en_c;

    initial begin
        rst = 1'b1; activity = 2'b00;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = 8'h00; cfg_wdata = 32'h0;
        en_a = '0; en_b = '0; en_c = '0;
        repeat (3) step();
        rst = 1'b0;

        check("rst_div_sel", 64'(div_sel), 64'h00);
        check("rst_clk_en", 64'(clk_en), 64'h3);
        check("rst_rvalid", 64'(cfg_rvalid), 64'h0);
        check("rst_rdata", 64'(cfg_rdata), 64'h0);

        // register map vectors: reads check {rvalid, rdata}
        add_vec("rd_ctrl",     1'b0, 8'h00, 32'h1);
        add_vec("rd_win_len",  1'b0, 8'h04, 32'hFF);
        add_vec("rd_thr_hi",   1'b0, 8'h08, 32'hC0);
        add_vec("rd_thr_lo",   1'b0, 8'h0C, 32'h20);
        add_vec("rd_div_max",  1'b0, 8'h10, 32'hF);
        add_vec("rd_ovr_en",   1'b0, 8'h14, 32'h0);
        add_vec("rd_ch0",      1'b0, 8'h20, 32'h0);
        add_vec("rd_ch1",      1'b0, 8'h24, 32'h0);
        add_vec("wr_thr_hi",   1'b1, 8'h08, 32'h6);
        add_vec("rd_thr_hi6",  1'b0, 8'h08, 32'h6);
        add_vec("wr_thr_lo",   1'b1, 8'h0C, 32'h1);
        add_vec("rd_thr_lo1",  1'b0, 8'h0C, 32'h1);
        add_vec("wr_unmapped", 1'b1, 8'h40, 32'h55);
        add_vec("rd_unmapped", 1'b0, 8'h40, 32'h0);
        add_vec("rd_gap_18",   1'b0, 8'h18, 32'h0);
        add_vec("wr_ovr3",     1'b1, 8'h14, 32'h3);
        add_vec("rd_ovr3",     1'b0, 8'h14, 32'h3);
        add_vec("wr_ovr0",     1'b1, 8'h14, 32'h0);

        for (int i = 0; i < n_vecs; i++) begin
            if (vecs[i].we) begin
                cfg_write(vecs[i].addr, vecs[i].data);
            end else begin
                cfg_read(vecs[i].addr, rd, rv);
                check(vecs[i].name, 64'({rv, rd}), 64'({1'b1, vecs[i].data}));
            end
        end
        step();
        check("rvalid_idle", 64'(cfg_rvalid), 64'h0);

        // idle windows of 8 cycles: DOWN every window, step every second one
        cfg_write(8'h04, 32'h8);
        for (int k = 1; k <= 48; k++) begin
            step();
            if (k >= 16 && k <= 21) en_a = {en_a[4:0], clk_en[0]};
            if (k >= 32 && k <= 37) en_b = {en_b[4:0], clk_en[0]};
            if (k == 15) check("w2_before_end", 64'(div_sel), 64'h00);
            if (k == 16) check("w2_step", 64'(div_sel), 64'h11);
            if (k == 31) check("w4_before_end", 64'(div_sel), 64'h11);
            if (k == 32) check("w4_step", 64'(div_sel), 64'h22);
            if (k == 48) check("w6_step", 64'(div_sel), 64'h33);
        end
        check("clk_en_div1", 64'(en_a), 64'(6'b101010));
        check("clk_en_div2", 64'(en_b), 64'(6'b100100));

        // hysteresis: UP, NEUTRAL, UP, UP on ch0; ch1 keeps going DOWN
        run_window(7, 1'b0);
        check("hyst_up1", 64'(div_sel), 64'h33);
        run_window(4, 1'b0);
        check("hyst_neutral", 64'(div_sel), 64'h43);
        run_window(7, 1'b1);
        check("hyst_up2", 64'(div_sel), 64'h43);
        run_window(7, 1'b1);
        check("hyst_step_up", 64'(div_sel), 64'h52);

        // boost: park ch1 at 15 through an override, release, then boost
        cfg_write(8'h04, 32'hFF);
        cfg_write(8'h24, 32'd15);
        cfg_write(8'h14, 32'h2);
        step();
        check("ovr_ch1_15", 64'(div_sel), 64'hF2);
        cfg_write(8'h14, 32'h0);
        step();
        check("ovr_release_hold", 64'(div_sel), 64'hF2);
        cfg_write(8'h00, 32'h3);
        activity = 2'b10;
        step();
        activity = 2'b00;
        check("boost_ch1", 64'(div_sel), 64'h02);
        for (int i = 0; i < 6; i++) begin
            en_c = {en_c[4:0], clk_en[1]};
            step();
        end
        check("boost_clk_en", 64'(en_c), 64'(6'b111111));
        cfg_write(8'h00, 32'h1);

        // override clipping and DIV_MAX clamp
        cfg_write(8'h10, 32'd15);
        cfg_write(8'h20, 32'd20);
        cfg_write(8'h14, 32'h1);
        step();
        check("ovr_clip_15", 64'(div_sel), 64'h0F);
        cfg_write(8'h10, 32'd9);
        check("div_max_clamp", 64'(div_sel), 64'h09);
        cfg_read(8'h10, rd, rv);
        check("rd_div_max9", 64'({rv, rd}), 64'({1'b1, 32'd9}));
        cfg_write(8'h14, 32'h0);
        repeat (4) step();
        check("release_hold9", 64'(div_sel), 64'h09);
        cfg_write(8'h04, 32'h8);
        activity = 2'b01;
        repeat (8) step();
        check("resume_w1", 64'(div_sel), 64'h09);
        repeat (8) step();
        activity = 2'b00;
        check("resume_w2", 64'(div_sel), 64'h18);

        // reset mid-window and mid-access
        cfg_write(8'h20, 32'd5);
        cfg_write(8'h14, 32'h1);
        step();
        cfg_write(8'h14, 32'h0);
        step();
        check("pre_rst_ch0", 64'(div_sel[3:0]), 64'h5);
        rst = 1'b1; cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h04;
        step();
        rst = 1'b0; cfg_req = 1'b0;
        check("mid_rst_div_sel", 64'(div_sel), 64'h00);
        check("mid_rst_clk_en", 64'(clk_en), 64'h3);
        check("mid_rst_rvalid", 64'(cfg_rvalid), 64'h0);
        cfg_read(8'h04, rd, rv);
        check("mid_rst_win_len", 64'({rv, rd}), 64'({1'b1, 32'hFF}));
        cfg_read(8'h14, rd, rv);
        check("mid_rst_ovr_en", 64'({rv, rd}), 64'({1'b1, 32'h0}));
        cfg_read(8'h10, rd, rv);
        check("mid_rst_div_max", 64'({rv, rd}), 64'({1'b1, 32'hF}));

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/avfs_dfs_ctrl.md
AVFS_DFS_CTRL -- requirements
Module: avfs_dfs_ctrl

Interface
REQ-001 The block SHALL have a parameter N_CH, default 2, giving the number of independently scaled clock domains.
REQ-002 The block SHALL have a parameter WIN_W, default 8, giving the width of the window length, activity counters and thresholds.
REQ-003 The block SHALL have a parameter DIV_W, default 4, giving the divider-select width per channel.
REQ-004 The block SHALL have a parameter HYST, default 2, giving the number of consecutive same-direction windows required before a step.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port activity_i, input, N_CH bits: per-channel busy indication (req|busy).
REQ-008 The block SHALL have ports cfg_req_i (input, 1), cfg_we_i (input, 1), cfg_addr_i (input, 8, byte address) and cfg_wdata_i (input, 32) forming the register access port.
REQ-009 The block SHALL have ports cfg_rvalid_o (output, 1) and cfg_rdata_o (output, 32) carrying read responses.
REQ-010 The block SHALL have port div_sel_o, output, N_CH*DIV_W bits: the current divider select, with channel n in bits [n*DIV_W +: DIV_W].
REQ-011 The block SHALL have port clk_en_o, output, N_CH bits: per-channel clock-enable pulse for a downstream clock gate.

Function
REQ-012 The register map SHALL be:
- 0x00 CTRL: bit0 EN, bit1 BOOST.
- 0x04 WIN_LEN.
- 0x08 THR_HI.
- 0x0C THR_LO.
- 0x10 DIV_MAX.
- 0x14 OVR_EN[N_CH-1:0].
- 0x20+4n CHn: write sets the override value; read returns div_sel[n].
- Unmapped addresses: reads return 0, writes are ignored.
REQ-013 Every cfg access SHALL be accepted in the cycle cfg_req_i is high. A write takes effect at the next edge. A read returns data with cfg_rvalid_o=1 exactly one cycle later.
REQ-014 A global window counter SHALL count 0..WIN_LEN-1, and window end is the cycle with count==WIN_LEN-1. WIN_LEN=0 SHALL behave as 1.
REQ-015 Per channel, a saturating WIN_W-bit activity counter SHALL count cycles with activity_i[n]=1, including the window-end cycle. It SHALL clear at window end.
REQ-016 A write to WIN_LEN SHALL restart the window, clearing the window counter and all activity counters.
REQ-017 At window end the per-channel request SHALL be decided in this order:
- count>=THR_HI: UP.
- else count<=THR_LO: DOWN.
- else: NEUTRAL.
UP SHALL take precedence when the thresholds overlap.
REQ-018 Hysteresis SHALL work per channel as follows:
- UP or DOWN matching the stored direction increments hyst_cnt.
- UP or DOWN opposite to the stored direction sets hyst_cnt=1 and stores the new direction.
- NEUTRAL clears hyst_cnt.
REQ-019 When hyst_cnt reaches HYST the channel SHALL step and clear hyst_cnt:
- UP: div_sel-1, saturating at 0.
- DOWN: div_sel+1, saturating at DIV_MAX.
The change SHALL be visible on div_sel_o the cycle after window end.
REQ-020 When BOOST=1 and activity_i[n]=1 with div_sel[n]!=0 on a non-overridden channel, div_sel[n] SHALL become 0 at the next edge and hyst_cnt SHALL clear. Boost SHALL take priority over a same-cycle window step.
REQ-021 When OVR_EN[n]=1, div_sel[n] SHALL equal min(CHn override, DIV_MAX) and hysteresis SHALL be held cleared. On release, div_sel SHALL keep its last value and autonomous control SHALL resume at the next window end.
REQ-022 Writing DIV_MAX below a current div_sel SHALL clamp that div_sel to DIV_MAX at the next edge.
REQ-023 When EN=0, the window and activity counters SHALL be held at 0, hysteresis SHALL be held cleared, div_sel SHALL hold, and clk_en generation SHALL continue.
REQ-024 Per channel, a divider counter SHALL count 0..div_sel[n] and wrap. clk_en_o[n]=(cnt==0), so clk_en_o[n] is constantly 1 when div_sel=0.
REQ-025 Any change of div_sel[n] SHALL force cnt[n]=0 at the next edge, so the new period starts with an enable pulse.

Reset
REQ-026 While rst_i=1 at an edge, the block SHALL load the following values:
- CTRL=0x1.
- WIN_LEN=2^WIN_W-1.
- THR_HI=3*2^(WIN_W-2).
- THR_LO=2^(WIN_W-3).
- DIV_MAX=2^DIV_W-1.
- OVR_EN=0 and all override values 0.
- All counters 0 and div_sel=0.
- cfg_rvalid_o=0 and cfg_rdata_o=0.
REQ-027 Reset asserted mid-window or mid-access SHALL discard all state. The cycle after reset, outputs SHALL be div_sel_o=0 and clk_en_o all ones.

Verification (N_CH=2, WIN_W=8, DIV_W=4, HYST=2)
REQ-028 Reset, then read 0x00 and 0x04 -> cfg_rdata_o=0x1 then 0xFF, each with cfg_rvalid_o one cycle after the request; div_sel_o=0x00, clk_en_o=2'b11.
REQ-029 WIN_LEN=8, THR_HI=6, THR_LO=1, activity_i=0 -> div_sel ch0 reaches 1 one cycle after the window-2 end and 2 after window 4; clk_en_o[0] pulses every 2 cycles, then every 3.
REQ-030 Ch0 at 3 receives windows with 7/8, 4/8, 7/8 and 7/8 active cycles -> no step until the end of the 4th window, then div_sel=2.
REQ-031 CTRL=0x3, ch1 at 15, single-cycle activity_i[1] pulse -> div_sel ch1=0 next cycle and clk_en_o[1]=1 continuously thereafter.
REQ-032 DIV_MAX=15, CH0=20, OVR_EN=01 -> div_sel ch0=15. Then DIV_MAX=9 -> ch0=9 next cycle. Then OVR_EN=00 -> ch0 stays 9 until the next window end.
REQ-033 div_sel ch0=5 mid-window, rst_i pulsed for 1 cycle -> next cycle div_sel_o=0, clk_en_o=2'b11, and a read of WIN_LEN returns 0xFF.
